// File: rtl/ccu_snoop_collector.sv
// ccu_snoop_collector
//   Snoop fan-out/fan-in stage. Takes one AC request plus a domain mask from
//   the upstream snoop controller, broadcasts the AC to every masked cached
//   master, ORs their CR responses into one merged CR, and then returns the CD
//   stream of the lowest-indexed data-transferring master. CD streams from the
//   other data-transferring masters are drained and dropped. One snoop is in
//   flight at a time.
//
// Ports
//   clk_i             clock, everything on its rising edge
//   rst_ni            asynchronous active-low reset
//   slv_snoop_req_i   AC/CR-ready/CD-ready from the upstream controller
//   slv_snoop_resp_o  AC-ready, merged CR and forwarded CD to the controller
//   domain_mask_i     target masters, qualified by slv_snoop_req_i.ac_valid
//   mst_snoop_req_o   per-master AC/CR-ready/CD-ready
//   mst_snoop_resp_i  per-master AC-ready/CR/CD
//
// Build option
//   CCU_SNOOP_MULTI_DIRTY_ERR_EN : when defined, more than one PassDirty CR in
//   a transaction sets merged Error (PassDirty stays set). When undefined,
//   PassDirty is a plain OR and Error is never injected.

package ccu_snoop_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_t;

  // Bit 0 is DataTransfer, matching the ACE CRRESP layout.
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } cr_resp_t;

  localparam int CR_W   = $bits(cr_resp_t);
  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;

  typedef struct packed {
    logic ac_valid;
    ac_t  ac;
    logic cd_ready;
    logic cr_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_resp_t cr_resp;
    logic     cd_valid;
    cd_t      cd;
  } snoop_resp_t;
endpackage

module ccu_snoop_collector
  import ccu_snoop_pkg::*;
#(
  parameter int unsigned N_MST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  snoop_req_t        slv_snoop_req_i,
  output snoop_resp_t       slv_snoop_resp_o,
  input  logic [N_MST-1:0]  domain_mask_i,
  output snoop_req_t        mst_snoop_req_o [N_MST],
  input  snoop_resp_t       mst_snoop_resp_i [N_MST]
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_AC_SEND    = 3'd1;
  localparam logic [2:0] ST_CR_COLLECT = 3'd2;
  localparam logic [2:0] ST_CR_OUT     = 3'd3;
  localparam logic [2:0] ST_CD_FWD     = 3'd4;

  localparam int SRC_W = (N_MST > 1) ? $clog2(N_MST) : 1;

  logic [2:0]       r_state, w_state_next;
  ac_t              r_ac;
  logic [N_MST-1:0] r_mask, r_ac_done, r_cr_done, r_cd_done, r_dt;
  logic [CR_W-1:0]  r_merge, w_merge_next;
  logic [SRC_W-1:0] r_src, w_src;

  logic             w_slv_ac_hs;
  logic [N_MST-1:0] w_ac_valid, w_cr_ready, w_cd_ready;
  logic [N_MST-1:0] w_ac_hs, w_cr_hs, w_cr_dt, w_cr_pd, w_cd_last_hs;

  assign w_slv_ac_hs = slv_snoop_req_i.ac_valid && (r_state == ST_IDLE);

  // Per-master request generation and handshake detection.
  for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
    assign w_ac_valid[gi] = (r_state == ST_AC_SEND) && r_mask[gi] && !r_ac_done[gi];
    assign w_cr_ready[gi] = (r_state == ST_CR_COLLECT) && r_mask[gi] && !r_cr_done[gi];
    // Source port follows the upstream ready; every other data port is drained.
    assign w_cd_ready[gi] = (r_state == ST_CD_FWD) && r_dt[gi] && !r_cd_done[gi] &&
                            ((r_src == SRC_W'(gi)) ? slv_snoop_req_i.cd_ready : 1'b1);

    always_comb begin
      mst_snoop_req_o[gi]          = '0;
      mst_snoop_req_o[gi].ac       = r_ac;
      mst_snoop_req_o[gi].ac_valid = w_ac_valid[gi];
      mst_snoop_req_o[gi].cr_ready = w_cr_ready[gi];
      mst_snoop_req_o[gi].cd_ready = w_cd_ready[gi];
    end

    assign w_ac_hs[gi]      = w_ac_valid[gi] && mst_snoop_resp_i[gi].ac_ready;
    assign w_cr_hs[gi]      = w_cr_ready[gi] && mst_snoop_resp_i[gi].cr_valid;
    assign w_cr_dt[gi]      = w_cr_hs[gi] && mst_snoop_resp_i[gi].cr_resp.data_transfer;
    assign w_cr_pd[gi]      = w_cr_hs[gi] && mst_snoop_resp_i[gi].cr_resp.pass_dirty;
    assign w_cd_last_hs[gi] = w_cd_ready[gi] && mst_snoop_resp_i[gi].cd_valid &&
                              mst_snoop_resp_i[gi].cd.last;
  end

  // Merge of all CRs accepted this cycle into the running merge.
  always_comb begin
    w_merge_next = r_merge;
    for (int i = 0; i < N_MST; i++) begin
      if (w_cr_hs[i]) begin
        w_merge_next = w_merge_next | mst_snoop_resp_i[i].cr_resp;
      end
    end
`ifdef CCU_SNOOP_MULTI_DIRTY_ERR_EN
    // Second dirty owner: either two arrive together, or one arrives after an
    // earlier one was already merged.
    if (((w_cr_pd & (w_cr_pd - N_MST'(1))) != '0) || (r_merge[CR_PD] && (|w_cr_pd))) begin
      w_merge_next[CR_ERR] = 1'b1;
    end
`endif
  end

  // Lowest-index data-transferring master becomes the forwarding source.
  always_comb begin
    w_src = '0;
    for (int i = N_MST - 1; i >= 0; i--) begin
      if (r_dt[i]) w_src = SRC_W'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:
        if (w_slv_ac_hs) w_state_next = (domain_mask_i == '0) ? ST_CR_OUT : ST_AC_SEND;
      ST_AC_SEND:
        if ((r_ac_done | w_ac_hs) == r_mask) w_state_next = ST_CR_COLLECT;
      ST_CR_COLLECT:
        if ((r_cr_done | w_cr_hs) == r_mask) w_state_next = ST_CR_OUT;
      ST_CR_OUT:
        if (slv_snoop_req_i.cr_ready) w_state_next = (|r_dt) ? ST_CD_FWD : ST_IDLE;
      ST_CD_FWD:
        if ((r_cd_done | w_cd_last_hs) == r_dt) w_state_next = ST_IDLE;
      default:
        w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_ac      <= '0;
      r_mask    <= '0;
      r_ac_done <= '0;
      r_cr_done <= '0;
      r_cd_done <= '0;
      r_dt      <= '0;
      r_merge   <= '0;
      r_src     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_slv_ac_hs) begin
            r_ac      <= slv_snoop_req_i.ac;
            r_mask    <= domain_mask_i;
            r_ac_done <= '0;
            r_cr_done <= '0;
            r_cd_done <= '0;
            r_dt      <= '0;
            r_merge   <= '0;
          end
        end
        ST_AC_SEND:    r_ac_done <= r_ac_done | w_ac_hs;
        ST_CR_COLLECT: begin
          r_cr_done <= r_cr_done | w_cr_hs;
          r_dt      <= r_dt | w_cr_dt;
          r_merge   <= w_merge_next;
        end
        ST_CR_OUT:     if (slv_snoop_req_i.cr_ready) r_src <= w_src;
        ST_CD_FWD:     r_cd_done <= r_cd_done | w_cd_last_hs;
        default: ;
      endcase
    end
  end

  // Upstream response: merged CR while in CR_OUT, source CD while forwarding.
  always_comb begin
    slv_snoop_resp_o          = '0;
    slv_snoop_resp_o.ac_ready = (r_state == ST_IDLE);
    if (r_state == ST_CR_OUT) begin
      slv_snoop_resp_o.cr_valid = 1'b1;
      slv_snoop_resp_o.cr_resp  = cr_resp_t'(r_merge);
    end
    if ((r_state == ST_CD_FWD) && !r_cd_done[r_src]) begin
      slv_snoop_resp_o.cd_valid = mst_snoop_resp_i[r_src].cd_valid;
      slv_snoop_resp_o.cd       = mst_snoop_resp_i[r_src].cd;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_collector.sv
module tb_ccu_snoop_collector;
  import ccu_snoop_pkg::*;

  localparam logic [4:0] DT  = 5'b00001;
  localparam logic [4:0] ERR = 5'b00010;
  localparam logic [4:0] PD  = 5'b00100;
  localparam logic [4:0] IS  = 5'b01000;
  localparam logic [4:0] WU  = 5'b10000;

  typedef struct {
    logic [3:0]      mask;
    logic [3:0][4:0] cr;
    logic [3:0][3:0] beats;
    logic [3:0][3:0] delay;
    logic [4:0]      exp_resp;
    int              exp_src;
    int              exp_cyc;
    bit              toggle;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  snoop_req_t  sreq;
  snoop_resp_t sresp;
  logic [3:0]  dmask;
  snoop_req_t  mreq  [4];
  snoop_resp_t mresp [4];

  int errors = 0;
  int checks = 0;

  // Responder configuration (written by the test) and state (responder only).
  logic [4:0] cfg_cr    [4] = '{5'd0, 5'd0, 5'd0, 5'd0};
  int         cfg_beats [4] = '{0, 0, 0, 0};
  int         cfg_delay [4] = '{0, 0, 0, 0};
  int         ac_hs_cnt [4] = '{0, 0, 0, 0};

  logic [4:0] exp_cr_q [$];
  cd_t        exp_cd_q [$];
  logic [3:0] cur_mask;
  vec_t       vecs [7];

  always #5 clk = ~clk;

  ccu_snoop_collector #(.N_MST(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_snoop_req_i  (sreq),
    .slv_snoop_resp_o (sresp),
    .domain_mask_i    (dmask),
    .mst_snoop_req_o  (mreq),
    .mst_snoop_resp_i (mresp)
  );

  // Cached-master models: sample handshakes at negedge, update after posedge.
  initial begin : responder
    int  rs_wait [4];
    int  rs_left [4];
    int  rs_beat [4];
    bit  rs_pend [4];
    bit  hs_ac [4], hs_cr [4], hs_cd [4], w_inc [4];
    for (int i = 0; i < 4; i++) begin
      mresp[i] = '0;
      rs_wait[i] = 0; rs_left[i] = 0; rs_beat[i] = 0; rs_pend[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        hs_ac[i] = mreq[i].ac_valid && mresp[i].ac_ready;
        w_inc[i] = mreq[i].ac_valid && !mresp[i].ac_ready;
        hs_cr[i] = mreq[i].cr_ready && mresp[i].cr_valid;
        hs_cd[i] = mreq[i].cd_ready && mresp[i].cd_valid;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!rst_n) begin
          rs_wait[i] = 0; rs_left[i] = 0; rs_beat[i] = 0; rs_pend[i] = 0;
          mresp[i] = '0;
        end else begin
          if (hs_ac[i]) begin
            rs_wait[i] = 0;
            rs_pend[i] = 1;
            ac_hs_cnt[i]++;
          end else if (w_inc[i]) begin
            rs_wait[i]++;
          end
          if (hs_cr[i]) begin
            rs_pend[i] = 0;
            if (cfg_cr[i][0]) begin
              rs_left[i] = cfg_beats[i];
              rs_beat[i] = 0;
            end
          end
          if (hs_cd[i]) begin
            rs_left[i]--;
            rs_beat[i]++;
          end
          mresp[i].ac_ready = (rs_wait[i] >= cfg_delay[i]);
          mresp[i].cr_valid = rs_pend[i];
          mresp[i].cr_resp  = cr_resp_t'(cfg_cr[i]);
          mresp[i].cd_valid = (rs_left[i] > 0);
          mresp[i].cd.data  = {32'(i), 32'(rs_beat[i])};
          mresp[i].cd.last  = (rs_left[i] == 1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] mask,
                               input logic [4:0] c3, input logic [4:0] c2,
                               input logic [4:0] c1, input logic [4:0] c0,
                               input logic [15:0] beats, input logic [4:0] exp_resp,
                               input int src, input int cyc, input bit tog);
    vec_t v;
    v.mask     = mask;
    v.cr       = {c3, c2, c1, c0};
    v.beats    = beats;
    v.delay    = '0;
    v.exp_resp = exp_resp;
    v.exp_src  = src;
    v.exp_cyc  = cyc;
    v.toggle   = tog;
    return v;
  endfunction

  function automatic logic any_mst_active();
    logic a = 1'b0;
    for (int i = 0; i < 4; i++) a |= mreq[i].ac_valid | mreq[i].cr_ready | mreq[i].cd_ready;
    return a;
  endfunction

  // One snoop: push expectations, issue AC, run until IDLE (or stop_cd beats).
  task automatic run_txn(input int id, input vec_t v, input int stop_cd);
    int base [4];
    int cyc, cr_cyc, ncd, leak, ovl;
    bit done, any_ac, any_cr;
    logic [4:0] e_cr;
    cd_t e_cd;
    for (int i = 0; i < 4; i++) begin
      cfg_cr[i]    = v.cr[i];
      cfg_beats[i] = int'(v.beats[i]);
      cfg_delay[i] = int'(v.delay[i]);
      base[i]      = ac_hs_cnt[i];
    end
    exp_cr_q.push_back(v.exp_resp);
    if (v.exp_src >= 0) begin
      for (int b = 0; b < int'(v.beats[v.exp_src]); b++) begin
        e_cd.data = {32'(v.exp_src), 32'(b)};
        e_cd.last = (b == int'(v.beats[v.exp_src]) - 1);
        exp_cd_q.push_back(e_cd);
      end
    end
    @(posedge clk);
    #1;
    sreq.ac_valid = 1'b1;
    sreq.ac.addr  = 32'h1000 + 32'(id) * 32'h100;
    sreq.cr_ready = 1'b1;
    sreq.cd_ready = 1'b0;
    dmask         = v.mask;
    cur_mask      = v.mask;
    @(negedge clk);
    chk("ac_ready_idle", 128'(sresp.ac_ready), 128'(1));
    cyc = 0; cr_cyc = -1; ncd = 0; leak = 0; ovl = 0; done = 0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      sreq.ac_valid = 1'b0;
      dmask         = 4'h0;
      sreq.cd_ready = v.toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      any_ac = 0; any_cr = 0;
      for (int i = 0; i < 4; i++) begin
        if (!cur_mask[i] && (mreq[i].ac_valid || mreq[i].cr_ready || mreq[i].cd_ready)) leak++;
        any_ac |= mreq[i].ac_valid;
        any_cr |= mreq[i].cr_ready;
      end
      if (any_ac && any_cr) ovl++;
      if (sresp.cr_valid && sreq.cr_ready) begin
        if (cr_cyc < 0) cr_cyc = cyc;
        if (exp_cr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cr_unexpected: got %0h, expected no response", sresp.cr_resp);
        end else begin
          e_cr = exp_cr_q.pop_front();
          chk("cr_resp", 128'(sresp.cr_resp), 128'(e_cr));
        end
      end
      if (sresp.cd_valid && sreq.cd_ready) begin
        ncd++;
        if (exp_cd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cd_unexpected: got %0h, expected no beat", sresp.cd.data);
        end else begin
          e_cd = exp_cd_q.pop_front();
          chk("cd_beat", 128'(sresp.cd), 128'(e_cd));
        end
      end
      if (stop_cd >= 0 && ncd == stop_cd) break;
      if (sresp.ac_ready) done = 1;
    end
    if (stop_cd < 0) begin
      chk("back_to_idle", 128'(done), 128'(1));
      chk("queues_empty", 128'(exp_cr_q.size() + exp_cd_q.size()), 128'(0));
      chk("cr_cycle", 128'(cr_cyc), 128'(v.exp_cyc));
      chk("unmasked_port_driven", 128'(leak), 128'(0));
      chk("ac_cr_overlap", 128'(ovl), 128'(0));
      for (int i = 0; i < 4; i++)
        chk($sformatf("ac_hs_cnt_p%0d", i), 128'(ac_hs_cnt[i] - base[i]), 128'(v.mask[i]));
    end
    $display("txn %0d mask=%b cr_cycle=%0d cd_beats=%0d cycles=%0d", id, v.mask, cr_cyc, ncd, cyc);
  endtask

  initial begin
    vec_t vd;
    vecs[0] = mkv(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 5'b00000, -1, 1, 0);
    vecs[1] = mkv(4'b0110, WU, IS, IS, PD | DT, 16'h0000, IS, -1, 3, 0);
    vecs[2] = mkv(4'b1111, DT, DT, 5'd0, 5'd0, 16'h4400, DT, 2, 3, 1);
`ifdef CCU_SNOOP_MULTI_DIRTY_ERR_EN
    vecs[3] = mkv(4'b0011, 5'd0, 5'd0, PD, PD, 16'h0000, PD | ERR, -1, 3, 0);
`else
    vecs[3] = mkv(4'b0011, 5'd0, 5'd0, PD, PD, 16'h0000, PD, -1, 3, 0);
`endif
    vecs[4] = mkv(4'b1000, WU | IS | DT, 5'd0, 5'd0, 5'd0, 16'h2000, WU | IS | DT, 3, 3, 0);
    vecs[5] = mkv(4'b0101, 5'd0, DT | PD, 5'd0, ERR, 16'h0100, ERR | PD | DT, 2, 3, 1);
    vecs[6] = mkv(4'b1111, IS, DT, DT, DT, 16'h0213, IS | DT, 0, 3, 0);

    rst_n = 1'b0;
    sreq  = '0;
    dmask = 4'h0;
    cur_mask = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ac_ready", 128'(sresp.ac_ready), 128'(1));
    chk("reset_valids", 128'({sresp.cr_valid, sresp.cd_valid, any_mst_active()}), 128'(0));

    for (int k = 0; k < 7; k++) run_txn(k, vecs[k], -1);

    // Port 1 holds off AC acceptance for 5 cycles.
    vd = mkv(4'b1011, IS, 5'd0, 5'd0, IS, 16'h0000, IS, -1, 8, 0);
    vd.delay = {4'd0, 4'd0, 4'd5, 4'd0};
    run_txn(7, vd, -1);

    // Reset while port 2's second beat is pending; a new snoop must then work.
    run_txn(8, vecs[2], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ac_ready", 128'(sresp.ac_ready), 128'(1));
    chk("midreset_valids", 128'({sresp.cr_valid, sresp.cd_valid, any_mst_active()}), 128'(0));
    exp_cr_q.delete();
    exp_cd_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(9, vecs[4], -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
